// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data ports), the single-port RAM
// and the arbiter that shares that RAM between them.
// slave  : the arbiter.
// master : everything around it (pipeline requesters and RAM read data).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  // data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;
  // RAM side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_addr, mem_write, mem_din
  );

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_addr, mem_write, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// data port. One grant per cycle, data port wins ties, and a saturating
// counter lets a starved fetch win once the data port has beaten it
// STARVE_MAX times. Read data appears one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_IF = 2'd1;
  localparam logic [1:0] WAIT_DM = 2'd2;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  // state_p1 names the port granted in the previous cycle
  logic [1:0]        state_p1;
  logic [SW-1:0]     starve_p1;
  logic              dm_we_p1;
  logic [DATA_W-1:0] if_hold_p1;
  logic [DATA_W-1:0] dm_hold_p1;

  logic eff_if, eff_dm, gnt_if, gnt_dm;
  logic if_valid, dm_valid, dm_rd_done;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s == STARVE_TOP) ? s : s + 1'b1;
  endfunction

  // Arbitration: a port is masked in the cycle its own access completes.
  always_comb begin
    eff_if = bus.if_req & ~bus.if_flush & (state_p1 != WAIT_IF);
    eff_dm = bus.dm_req & (state_p1 != WAIT_DM);
    gnt_dm = eff_dm & ~(eff_if & (starve_p1 == STARVE_TOP));
    gnt_if = eff_if & ~gnt_dm;
  end

  // RAM address/write mux driven straight from the grant; writes blocked in reset.
  always_comb begin
    bus.mem_addr  = bus.if_addr;
    bus.mem_write = 1'b0;
    bus.mem_din   = '0;
    if (gnt_dm) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_write = bus.dm_we & ~reset;
      bus.mem_din   = bus.dm_wdata;
    end
  end

  // Completion and read-data bypass. A flush in the completion cycle hides the
  // fetch combinationally, so no extra kill state is needed.
  always_comb begin
    if_valid     = (state_p1 == WAIT_IF) & ~bus.if_flush;
    dm_valid     = (state_p1 == WAIT_DM);
    dm_rd_done   = dm_valid & ~dm_we_p1;
    bus.if_valid = if_valid;
    bus.dm_valid = dm_valid;
    bus.if_stall = bus.if_req & ~if_valid;
    bus.dm_stall = bus.dm_req & ~dm_valid;
    bus.if_rdata = if_valid   ? bus.mem_dout : if_hold_p1;
    bus.dm_rdata = dm_rd_done ? bus.mem_dout : dm_hold_p1;
  end

  // ---- grant stage -> completion stage ----
  // Control: grant state and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= IDLE;
      starve_p1 <= '0;
    end else begin
      state_p1 <= gnt_dm ? WAIT_DM : (gnt_if ? WAIT_IF : IDLE);
      if (gnt_if | ~bus.if_req)
        starve_p1 <= '0;
      else if (eff_if & gnt_dm)
        starve_p1 <= sat_inc(starve_p1);
    end
  end

  // Remember whether the granted data access was a store (no rdata update).
  always_ff @(posedge clk) begin
    if (gnt_dm)
      dm_we_p1 <= bus.dm_we;
  end

  // Read-data hold registers; cleared by reset so outputs start at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_hold_p1 <= '0;
      dm_hold_p1 <= '0;
    end else begin
      if (if_valid)   if_hold_p1 <= bus.mem_dout;
      if (dm_rd_done) dm_hold_p1 <= bus.mem_dout;
    end
  end

endmodule
